execution_mdu: RTL and testbench
================================

// Module: execution_mdu
// PURPOSE
//  Parametrised EX stage: single-cycle ALU plus iterative RV32M/RV64M multiply/divide unit (MDU).
//  Sits between decode and memory stages; valid/ready on input, one-cycle o_valid pulse on output.
//  Variable latency: ALU 1 cycle, MDU XLEN+1 cycles. i_flush kills in-flight work.
// PARAMETERS
//  XLEN            32  datapath width; power of two, >= 8
//  REG_ADDR_WIDTH  5   destination register address width
// PORTS
//  clk          in   1               clock, rising edge
//  rst          in   1               synchronous reset, active-high
//  clk_en       in   1               clock enable; low = all state holds
//  i_valid      in   1               operation offered
//  o_ready      out  1               = (state==IDLE); accept = i_valid & o_ready & clk_en & !i_flush
//  i_flush      in   1               kill in-flight op, drop output
//  i_alu_src1   in   1               SrcA: 0 = i_rs1, 1 = i_pc
//  i_alu_src2   in   1               SrcB: 0 = i_rs2, 1 = i_imm
//  i_pc         in   XLEN            program counter
//  i_rs1        in   XLEN            RS1 value
//  i_rs2        in   XLEN            RS2 value
//  i_imm        in   XLEN            sign-extended immediate
//  i_alu_op     in   4               0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND; 10-15 -> 0
//  i_mdu        in   1               1 = MDU op (i_alu_op ignored)
//  i_mdu_op     in   3               funct3: MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU
//  i_rd         in   REG_ADDR_WIDTH  destination register
//  i_reg_wr     in   1               register write enable
//  o_valid      out  1               result valid, one cycle per completed op
//  o_result     out  XLEN            ALU/MDU result
//  o_rd         out  REG_ADDR_WIDTH  destination, captured at accept
//  o_reg_wr     out  1               = captured i_reg_wr & o_valid
//  o_data2      out  XLEN            i_rs2 captured at accept (store data)
//  o_busy       out  1               state != IDLE
// BEHAVIOUR
//  Reset (rst, overrides clk_en): state IDLE, counter 0, all outputs 0.
//  States: IDLE -> BUSY on MDU accept; BUSY -> FIN after XLEN enabled cycles; FIN -> IDLE.
//  ALU accept: o_valid=1 next edge, o_result = ALU(SrcA,SrcB); state stays IDLE.
//  Shifts use SrcB[$clog2(XLEN)-1:0]; SRA arithmetic; SLT signed, SLTU unsigned, result 0/1.
//  MDU: operands captured at accept; magnitudes for signed forms; shift-add multiply (2*XLEN product)
//   or restoring divide, one bit per enabled cycle over XLEN cycles in BUSY.
//  FIN edge applies sign correction, selects low/high half or quotient/remainder, o_valid=1.
//  MDU latency: accept edge E0 -> o_valid at edge E(XLEN+1); o_ready low E0..E(XLEN+1).
//  MULHSU: rs1 signed, rs2 unsigned. Truncation: MUL = low XLEN bits, MULH* = high XLEN bits.
//  Divide by zero: DIV/DIVU -> all ones; REM/REMU -> dividend. Full latency still applies.
//  Overflow DIV(-2^(XLEN-1), -1) -> -2^(XLEN-1); REM -> 0.
//  Quotient rounds toward zero; remainder takes sign of dividend.
//  Any enabled edge without completion: o_valid=0, o_reg_wr=0; o_result/o_rd/o_data2 hold.
//  i_flush & clk_en: state IDLE, o_valid=0, counter 0; takes priority over accept and FIN
//   (no accept, no completion that cycle).
//  clk_en=0: state, counter, outputs all hold (o_valid held too); no accept.
//  i_valid while BUSY/FIN: ignored (o_ready=0); upstream must hold.
//  No output backpressure: downstream always takes o_valid.
// TESTING (XLEN=32)
//  ADD, rs1=5, imm=0xFFFFFFFD, alu_src2=1 -> next cycle o_valid=1, o_result=2, o_ready stays 1.
//  MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE at E33, o_ready=0 E0..E33; MULH(-1,-1) -> 0; MUL -> 1.
//  DIV 7/0 -> 0xFFFFFFFF; REM 7/0 -> 7; DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
//  DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 0xFFFFFFF9/2 -> 0x7FFFFFFC.
//  i_flush on 10th BUSY cycle of MUL -> no o_valid; o_ready=1 next cycle; next ADD accepted.
//  clk_en low 5 cycles mid-DIV -> o_valid at E38, correct result; rst mid-MUL -> all outputs 0, IDLE.

Source files
------------

// File: rtl/execution_mdu.sv
// EX stage: single-cycle ALU plus an iterative RV32M/RV64M multiply/divide unit.
// ALU results appear one edge after accept; MDU results appear XLEN+1 edges after accept.
module execution_mdu #(
  parameter int XLEN           = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clk_en,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic                      i_flush,
  input  logic                      i_alu_src1,
  input  logic                      i_alu_src2,
  input  logic [XLEN-1:0]           i_pc,
  input  logic [XLEN-1:0]           i_rs1,
  input  logic [XLEN-1:0]           i_rs2,
  input  logic [XLEN-1:0]           i_imm,
  input  logic [3:0]                i_alu_op,
  input  logic                      i_mdu,
  input  logic [2:0]                i_mdu_op,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  input  logic                      i_reg_wr,
  output logic                      o_valid,
  output logic [XLEN-1:0]           o_result,
  output logic [REG_ADDR_WIDTH-1:0] o_rd,
  output logic                      o_reg_wr,
  output logic [XLEN-1:0]           o_data2,
  output logic                      o_busy
);

  localparam int SW = $clog2(XLEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                      state_r, state_s;
  logic [SW-1:0]               cnt_r;
  logic [2*XLEN-1:0]           prod_r, prod_s, prod_neg_s;
  logic [XLEN-1:0]             opnd_r, dividend_r, data2_r;
  logic [2:0]                  op_r;
  logic                        neg_prod_r, neg_rem_r, div_zero_r, reg_wr_r;
  logic [REG_ADDR_WIDTH-1:0]   rd_r;

  logic [XLEN-1:0]             src_a_s, src_b_s, alu_s, mdu_s, abs_a_s, abs_b_s;
  logic [XLEN-1:0]             quot_neg_s, rem_neg_s;
  logic [XLEN:0]               mul_sum_s, rem_sh_s, rem_diff_s;
  logic                        a_neg_s, b_neg_s;
  logic                        accept_s, alu_acc_s, mdu_acc_s, fin_s, last_s;

  assign o_ready = (state_r == IDLE);
  assign o_busy  = (state_r != IDLE);

  // ALU datapath on the selected sources
  always_comb begin
    src_a_s = i_alu_src1 ? i_pc  : i_rs1;
    src_b_s = i_alu_src2 ? i_imm : i_rs2;
    case (i_alu_op)
      4'd0:    alu_s = src_a_s + src_b_s;
      4'd1:    alu_s = src_a_s - src_b_s;
      4'd2:    alu_s = src_a_s << src_b_s[SW-1:0];
      4'd3:    alu_s = {{(XLEN-1){1'b0}}, ($signed(src_a_s) < $signed(src_b_s))};
      4'd4:    alu_s = {{(XLEN-1){1'b0}}, (src_a_s < src_b_s)};
      4'd5:    alu_s = src_a_s ^ src_b_s;
      4'd6:    alu_s = src_a_s >> src_b_s[SW-1:0];
      4'd7:    alu_s = $signed(src_a_s) >>> src_b_s[SW-1:0];
      4'd8:    alu_s = src_a_s | src_b_s;
      4'd9:    alu_s = src_a_s & src_b_s;
      default: alu_s = {XLEN{1'b0}};
    endcase
  end

  // Operand signedness per funct3; iteration always runs on magnitudes
  always_comb begin
    case (i_mdu_op)
      3'd1, 3'd4, 3'd6: begin
        a_neg_s = i_rs1[XLEN-1];
        b_neg_s = i_rs2[XLEN-1];
      end
      3'd2: begin
        a_neg_s = i_rs1[XLEN-1];
        b_neg_s = 1'b0;
      end
      default: begin
        a_neg_s = 1'b0;
        b_neg_s = 1'b0;
      end
    endcase
    abs_a_s = a_neg_s ? (~i_rs1 + {{(XLEN-1){1'b0}}, 1'b1}) : i_rs1;
    abs_b_s = b_neg_s ? (~i_rs2 + {{(XLEN-1){1'b0}}, 1'b1}) : i_rs2;
  end

  // One iteration: shift-add multiply, or restoring divide with {rem, quot} in prod_r
  always_comb begin
    mul_sum_s  = {1'b0, prod_r[2*XLEN-1:XLEN]} + {1'b0, opnd_r};
    rem_sh_s   = {prod_r[2*XLEN-1:XLEN], prod_r[XLEN-1]};
    rem_diff_s = rem_sh_s - {1'b0, opnd_r};
    if (!op_r[2]) begin
      if (prod_r[0]) begin
        prod_s = {mul_sum_s, prod_r[XLEN-1:1]};
      end else begin
        prod_s = {1'b0, prod_r[2*XLEN-1:1]};
      end
    end else if (rem_sh_s >= {1'b0, opnd_r}) begin
      prod_s = {rem_diff_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b1};
    end else begin
      prod_s = {rem_sh_s[XLEN-1:0], prod_r[XLEN-2:0], 1'b0};
    end
  end

  // Final sign correction and half/quotient/remainder selection
  always_comb begin
    prod_neg_s = ~prod_r + {{(2*XLEN-1){1'b0}}, 1'b1};
    quot_neg_s = ~prod_r[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1};
    rem_neg_s  = ~prod_r[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1};
    case (op_r)
      3'd0:             mdu_s = neg_prod_r ? prod_neg_s[XLEN-1:0] : prod_r[XLEN-1:0];
      3'd1, 3'd2, 3'd3: mdu_s = neg_prod_r ? prod_neg_s[2*XLEN-1:XLEN] : prod_r[2*XLEN-1:XLEN];
      3'd4, 3'd5: begin
        if (div_zero_r) begin
          mdu_s = {XLEN{1'b1}};
        end else begin
          mdu_s = neg_prod_r ? quot_neg_s : prod_r[XLEN-1:0];
        end
      end
      default: begin
        if (div_zero_r) begin
          mdu_s = dividend_r;
        end else begin
          mdu_s = neg_rem_r ? rem_neg_s : prod_r[2*XLEN-1:XLEN];
        end
      end
    endcase
  end

  // Handshake and sequencing qualifiers; flush masks both accept and completion
  always_comb begin
    accept_s  = i_valid & (state_r == IDLE) & clk_en & ~i_flush;
    alu_acc_s = accept_s & ~i_mdu;
    mdu_acc_s = accept_s & i_mdu;
    fin_s     = (state_r == FIN) & ~i_flush;
    last_s    = (state_r == BUSY) & (cnt_r == SW'(XLEN - 1));
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    if (i_flush) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    state_s = mdu_acc_s ? BUSY : IDLE;
        BUSY:    state_s = last_s ? FIN : BUSY;
        FIN:     state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else if (clk_en) begin
      state_r <= state_s;
    end
  end

  // Operand capture, iteration registers and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {SW{1'b0}};
      prod_r     <= {(2*XLEN){1'b0}};
      opnd_r     <= {XLEN{1'b0}};
      dividend_r <= {XLEN{1'b0}};
      data2_r    <= {XLEN{1'b0}};
      op_r       <= 3'd0;
      neg_prod_r <= 1'b0;
      neg_rem_r  <= 1'b0;
      div_zero_r <= 1'b0;
      reg_wr_r   <= 1'b0;
      rd_r       <= {REG_ADDR_WIDTH{1'b0}};
      o_valid    <= 1'b0;
      o_result   <= {XLEN{1'b0}};
      o_rd       <= {REG_ADDR_WIDTH{1'b0}};
      o_reg_wr   <= 1'b0;
      o_data2    <= {XLEN{1'b0}};
    end else if (clk_en) begin
      if (i_flush) begin
        cnt_r    <= {SW{1'b0}};
        o_valid  <= 1'b0;
        o_reg_wr <= 1'b0;
      end else begin
        o_valid  <= alu_acc_s | fin_s;
        o_reg_wr <= (alu_acc_s & i_reg_wr) | (fin_s & reg_wr_r);
        if (alu_acc_s) begin
          o_result <= alu_s;
          o_rd     <= i_rd;
          o_data2  <= i_rs2;
        end else if (fin_s) begin
          o_result <= mdu_s;
          o_rd     <= rd_r;
          o_data2  <= data2_r;
        end
        if (mdu_acc_s) begin
          cnt_r      <= {SW{1'b0}};
          prod_r     <= {{XLEN{1'b0}}, abs_a_s};
          opnd_r     <= abs_b_s;
          dividend_r <= i_rs1;
          data2_r    <= i_rs2;
          op_r       <= i_mdu_op;
          neg_prod_r <= a_neg_s ^ b_neg_s;
          neg_rem_r  <= a_neg_s;
          div_zero_r <= (i_rs2 == {XLEN{1'b0}});
          reg_wr_r   <= i_reg_wr;
          rd_r       <= i_rd;
        end else if (state_r == BUSY) begin
          prod_r <= prod_s;
          cnt_r  <= last_s ? {SW{1'b0}} : cnt_r + SW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_execution_mdu.sv
// Directed self-checking bench for execution_mdu at XLEN=32.
module tb_execution_mdu;

  logic        clk = 1'b0;
  logic        rst, clk_en, i_valid, o_ready, i_flush, i_alu_src1, i_alu_src2;
  logic [31:0] i_pc, i_rs1, i_rs2, i_imm, o_result, o_data2;
  logic [3:0]  i_alu_op;
  logic        i_mdu, i_reg_wr, o_valid, o_reg_wr, o_busy;
  logic [2:0]  i_mdu_op;
  logic [4:0]  i_rd, o_rd;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  execution_mdu #(.XLEN(32), .REG_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_valid(i_valid), .o_ready(o_ready),
    .i_flush(i_flush), .i_alu_src1(i_alu_src1), .i_alu_src2(i_alu_src2), .i_pc(i_pc),
    .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_alu_op(i_alu_op), .i_mdu(i_mdu),
    .i_mdu_op(i_mdu_op), .i_rd(i_rd), .i_reg_wr(i_reg_wr), .o_valid(o_valid),
    .o_result(o_result), .o_rd(o_rd), .o_reg_wr(o_reg_wr), .o_data2(o_data2), .o_busy(o_busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [3:0] op, input logic s1, input logic s2,
                           input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic [4:0] rd, input logic wr);
    i_valid = 1'b1; i_mdu = 1'b0; i_alu_op = op; i_alu_src1 = s1; i_alu_src2 = s2;
    i_pc = pc; i_rs1 = a; i_rs2 = b; i_imm = imm; i_rd = rd; i_reg_wr = wr;
    tick();
    i_valid = 1'b0;
  endtask

  // Accepts one MDU op and waits (bounded) for its o_valid; lat stays 0 on timeout
  task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int stall_at, input int stall_len,
                         output logic [31:0] res, output int lat, output bit ready_ok);
    i_valid = 1'b1; i_mdu = 1'b1; i_mdu_op = op; i_rs1 = a; i_rs2 = b; i_rd = rd; i_reg_wr = 1'b1;
    tick();
    i_valid = 1'b0; i_mdu = 1'b0;
    ready_ok = (o_ready === 1'b0) && (o_busy === 1'b1);
    lat = 0;
    res = 32'h0;
    for (int k = 1; k <= 80; k++) begin
      clk_en = !(k >= stall_at && k < stall_at + stall_len);
      tick();
      if (o_valid === 1'b1) begin
        lat = k;
        res = o_result;
        break;
      end
      if (o_ready !== 1'b0) ready_ok = 1'b0;
    end
    clk_en = 1'b1;
  endtask

  task automatic test_reset();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", o_valid); end
    n_cmp++; if (o_result !== 32'h0) begin n_bad++; $display("FAIL reset_result got %h want 0", o_result); end
    n_cmp++; if (o_rd !== 5'd0) begin n_bad++; $display("FAIL reset_rd got %0d want 0", o_rd); end
    n_cmp++; if (o_reg_wr !== 1'b0) begin n_bad++; $display("FAIL reset_reg_wr got %b want 0", o_reg_wr); end
    n_cmp++; if (o_data2 !== 32'h0) begin n_bad++; $display("FAIL reset_data2 got %h want 0", o_data2); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready got %b want 1", o_ready); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", o_busy); end
  endtask

  // Issues one ALU op per cycle, back to back, and checks each result one edge later
  task automatic test_alu();
    logic [3:0]  op  [12];
    logic [31:0] a   [12];
    logic [31:0] b   [12];
    logic [31:0] exp [12];
    logic        s1, s2;
    op  = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd12, 4'd0};
    a   = '{32'd5, 32'd3, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'h80000000,
            32'h80000000, 32'h0000F000, 32'hF0F0F0F0, 32'd5, 32'd0};
    b   = '{32'd0, 32'd5, 32'd33, 32'd1, 32'd1, 32'hFF00FF00, 32'd4, 32'd4, 32'h0000000F,
            32'hFF00FF00, 32'd3, 32'd0};
    exp = '{32'd2, 32'hFFFFFFFE, 32'd2, 32'd1, 32'd0, 32'h0FF00FF0, 32'h08000000,
            32'hF8000000, 32'h0000F00F, 32'hF000F000, 32'd0, 32'h00001010};
    for (int i = 0; i < 12; i++) begin
      s1 = (i == 11);
      s2 = (i == 0) || (i == 11);
      drive_alu(op[i], s1, s2, 32'h00001000, a[i], b[i], (i == 0) ? 32'hFFFFFFFD : 32'h10,
                5'(i + 1), i[0]);
      n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL alu_valid[%0d] got %b want 1", i, o_valid); end
      n_cmp++; if (o_result !== exp[i]) begin n_bad++; $display("FAIL alu_result[%0d] got %h want %h", i, o_result, exp[i]); end
      n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL alu_ready[%0d] got %b want 1", i, o_ready); end
      n_cmp++; if (o_rd !== 5'(i + 1)) begin n_bad++; $display("FAIL alu_rd[%0d] got %0d want %0d", i, o_rd, i + 1); end
      n_cmp++; if (o_reg_wr !== i[0]) begin n_bad++; $display("FAIL alu_reg_wr[%0d] got %b want %b", i, o_reg_wr, i[0]); end
      n_cmp++; if (o_data2 !== b[i]) begin n_bad++; $display("FAIL alu_data2[%0d] got %h want %h", i, o_data2, b[i]); end
    end
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL alu_idle_valid got %b want 0", o_valid); end
    n_cmp++; if (o_result !== 32'h00001010) begin n_bad++; $display("FAIL alu_hold_result got %h want 00001010", o_result); end
  endtask

  task automatic test_mdu();
    logic [2:0]  op  [17];
    logic [31:0] a   [17];
    logic [31:0] b   [17];
    logic [31:0] exp [17];
    logic [31:0] res;
    int          lat;
    bit          rok;
    op  = '{3'd3, 3'd1, 3'd0, 3'd0, 3'd2, 3'd1, 3'd4, 3'd6, 3'd4, 3'd6, 3'd4, 3'd6, 3'd5,
            3'd7, 3'd4, 3'd6, 3'd5};
    a   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd6, 32'hFFFFFFFF, 32'h80000000,
            32'd7, 32'd7, 32'h80000000, 32'h80000000, 32'hFFFFFFF9, 32'hFFFFFFF9,
            32'hFFFFFFF9, 32'd100, 32'd7, 32'd7, 32'd5};
    b   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'd2, 32'h80000000,
            32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2,
            32'd2, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0};
    exp = '{32'hFFFFFFFE, 32'd0, 32'd1, 32'd42, 32'hFFFFFFFF, 32'h40000000,
            32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0, 32'hFFFFFFFD, 32'hFFFFFFFF,
            32'h7FFFFFFC, 32'd2, 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF};
    for (int i = 0; i < 17; i++) begin
      run_mdu(op[i], a[i], b[i], 5'(i + 3), 0, 0, res, lat, rok);
      n_cmp++; if (res !== exp[i]) begin n_bad++; $display("FAIL mdu_result[%0d] op%0d got %h want %h", i, op[i], res, exp[i]); end
      n_cmp++; if (lat !== 33) begin n_bad++; $display("FAIL mdu_latency[%0d] got %0d want 33", i, lat); end
      n_cmp++; if (rok !== 1'b1) begin n_bad++; $display("FAIL mdu_ready_low[%0d] got %b want 1", i, rok); end
      n_cmp++; if (o_rd !== 5'(i + 3)) begin n_bad++; $display("FAIL mdu_rd[%0d] got %0d want %0d", i, o_rd, i + 3); end
      n_cmp++; if (o_reg_wr !== 1'b1) begin n_bad++; $display("FAIL mdu_reg_wr[%0d] got %b want 1", i, o_reg_wr); end
      n_cmp++; if (o_data2 !== b[i]) begin n_bad++; $display("FAIL mdu_data2[%0d] got %h want %h", i, o_data2, b[i]); end
    end
    tick();
    n_cmp++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin n_bad++; $display("FAIL mdu_after got valid %b ready %b want 0 1", o_valid, o_ready); end
  endtask

  task automatic test_flush();
    bit seen;
    i_valid = 1'b1; i_mdu = 1'b1; i_mdu_op = 3'd0; i_rs1 = 32'd6; i_rs2 = 32'd7;
    tick();
    i_valid = 1'b0; i_mdu = 1'b0;
    repeat (9) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_valid got %b want 0", o_valid); end
    n_cmp++; if (o_ready !== 1'b1) begin n_bad++; $display("FAIL flush_ready got %b want 1", o_ready); end
    n_cmp++; if (o_busy !== 1'b0) begin n_bad++; $display("FAIL flush_busy got %b want 0", o_busy); end
    i_flush = 1'b1;
    drive_alu(4'd0, 1'b0, 1'b0, 32'h0, 32'd8, 32'd9, 32'h0, 5'd4, 1'b1);
    i_flush = 1'b0;
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL flush_blocks_accept got valid %b want 0", o_valid); end
    drive_alu(4'd0, 1'b0, 1'b0, 32'h0, 32'd1, 32'd2, 32'h0, 5'd9, 1'b1);
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL flush_next_add_valid got %b want 1", o_valid); end
    n_cmp++; if (o_result !== 32'd3) begin n_bad++; $display("FAIL flush_next_add_result got %h want 3", o_result); end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (o_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL flush_stray_valid got %b want 0", seen); end
  endtask

  task automatic test_clk_en();
    logic [31:0] res;
    int          lat;
    bit          rok;
    drive_alu(4'd0, 1'b0, 1'b0, 32'h0, 32'd10, 32'd20, 32'h0, 5'd2, 1'b1);
    clk_en = 1'b0;
    i_valid = 1'b1; i_rs1 = 32'd1; i_rs2 = 32'd1;
    repeat (3) tick();
    n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL clken_hold_valid got %b want 1", o_valid); end
    n_cmp++; if (o_result !== 32'd30) begin n_bad++; $display("FAIL clken_hold_result got %h want 1e", o_result); end
    i_valid = 1'b0;
    clk_en = 1'b1;
    tick();
    n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL clken_no_accept_valid got %b want 0", o_valid); end
    n_cmp++; if (o_result !== 32'd30) begin n_bad++; $display("FAIL clken_no_accept_result got %h want 1e", o_result); end
    run_mdu(3'd4, 32'hFFFFFFF9, 32'd2, 5'd7, 10, 5, res, lat, rok);
    n_cmp++; if (lat !== 38) begin n_bad++; $display("FAIL clken_div_latency got %0d want 38", lat); end
    n_cmp++; if (res !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL clken_div_result got %h want fffffffd", res); end
    n_cmp++; if (rok !== 1'b1) begin n_bad++; $display("FAIL clken_div_ready_low got %b want 1", rok); end
  endtask

  task automatic test_rst_mid();
    bit seen;
    i_valid = 1'b1; i_mdu = 1'b1; i_mdu_op = 3'd0; i_rs1 = 32'd3; i_rs2 = 32'd4;
    tick();
    i_valid = 1'b0; i_mdu = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    clk_en = 1'b0;
    tick();
    rst = 1'b0;
    clk_en = 1'b1;
    n_cmp++; if (o_result !== 32'h0) begin n_bad++; $display("FAIL rst_mid_result got %h want 0", o_result); end
    n_cmp++; if (o_rd !== 5'd0) begin n_bad++; $display("FAIL rst_mid_rd got %0d want 0", o_rd); end
    n_cmp++; if (o_data2 !== 32'h0) begin n_bad++; $display("FAIL rst_mid_data2 got %h want 0", o_data2); end
    n_cmp++; if (o_valid !== 1'b0 || o_reg_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got %b %b want 0 0", o_valid, o_reg_wr); end
    n_cmp++; if (o_ready !== 1'b1 || o_busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_state got ready %b busy %b want 1 0", o_ready, o_busy); end
    seen = 1'b0;
    repeat (40) begin
      tick();
      if (o_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (seen !== 1'b0) begin n_bad++; $display("FAIL rst_mid_stray_valid got %b want 0", seen); end
  endtask

  initial begin
    rst = 1'b1; clk_en = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_alu_src1 = 1'b0;
    i_alu_src2 = 1'b0; i_pc = 32'h0; i_rs1 = 32'h0; i_rs2 = 32'h0; i_imm = 32'h0;
    i_alu_op = 4'd0; i_mdu = 1'b0; i_mdu_op = 3'd0; i_rd = 5'd0; i_reg_wr = 1'b0;
    repeat (3) tick();
    test_reset();
    rst = 1'b0;
    test_alu();
    test_mdu();
    test_flush();
    test_clk_en();
    test_rst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
